// File: rtl/muldiv_ctrl.sv
// HI/LO owner and iterative 32-cycle multiply/divide sequencer for the MIPS execute stage.
// Operands are reduced to magnitudes on accept; signs are re-applied in a single fix-up cycle.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  func,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]  state;
    logic [5:0]  count;
    logic [63:0] acc;
    logic [31:0] opnd;
    logic        neg_q, neg_r, op_div, div0;

    logic        is_md, is_mv, signed_op, accept;
    logic [31:0] a_mag, b_mag;
    logic [32:0] madd;
    logic [33:0] dsub;
    logic        dge;
    logic [63:0] acc_next, prod_fix;
    logic [31:0] q_fix, r_fix;

    assign is_md     = (func == F_MULT) | (func == F_MULTU) | (func == F_DIV) | (func == F_DIVU);
    assign is_mv     = (func == F_MFHI) | (func == F_MTHI) | (func == F_MFLO) | (func == F_MTLO);
    assign signed_op = (func == F_MULT) | (func == F_DIV);
    assign busy      = (state != IDLE);
    assign stall     = busy & start & (is_md | is_mv);
    assign accept    = start & ~busy & ~flush;
    assign rd_data   = (func == F_MFHI) ? hi : lo;

    assign a_mag = (signed_op & A[31]) ? -A : A;
    assign b_mag = (signed_op & B[31]) ? -B : B;

    // Shifted remainder can reach 33 bits; a non-negative difference always fits in 32.
    assign madd = {1'b0, acc[63:32]} + {1'b0, opnd};
    assign dsub = {1'b0, acc[63:31]} - {2'b00, opnd};
    assign dge  = ~|dsub[33:32];

    always_comb begin
        acc_next = acc;
        if (op_div)
            acc_next = dge ? {dsub[31:0], acc[30:0], 1'b1} : {acc[62:0], 1'b0};
        else
            acc_next = acc[0] ? {madd, acc[31:1]} : {1'b0, acc[63:1]};
    end

    assign prod_fix = neg_q ? -acc : acc;
    assign q_fix    = neg_q ? -acc[31:0] : acc[31:0];
    assign r_fix    = neg_r ? -acc[63:32] : acc[63:32];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= 6'd0;
            acc    <= 64'd0;
            opnd   <= 32'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            op_div <= 1'b0;
            div0   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && is_md) begin
                        state  <= CALC;
                        count  <= 6'd0;
                        op_div <= func[1];
                        div0   <= func[1] & (B == 32'd0);
                        neg_q  <= signed_op & (A[31] ^ B[31]);
                        neg_r  <= signed_op & A[31];
                        acc    <= {32'd0, func[1] ? a_mag : b_mag};
                        // A zero divisor leaves opnd free, so it carries the raw dividend for HI.
                        opnd   <= func[1] ? ((B == 32'd0) ? A : b_mag) : a_mag;
                    end else if (accept && func == F_MTHI) begin
                        hi <= A;
                    end else if (accept && func == F_MTLO) begin
                        lo <= A;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc   <= acc_next;
                        count <= count + 6'd1;
                        if (count == 6'd31)
                            state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!flush) begin
                        done <= 1'b1;
                        if (!op_div) begin
                            hi <= prod_fix[63:32];
                            lo <= prod_fix[31:0];
                        end else if (div0) begin
                            hi <= opnd;
                            lo <= 32'hFFFF_FFFF;
                        end else begin
                            hi <= r_fix;
                            lo <= q_fix;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes expected {HI,LO} computed with plain
// 64-bit arithmetic; a monitor pops and compares on every done pulse.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  func = 6'h0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        busy, stall, done;
    logic [31:0] hi, lo, rd_data;

    muldiv_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func(func), .A(a), .B(b), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    logic [63:0] exp_q[$];
    int total = 0;
    int passed = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Expected {HI,LO} from MIPS semantics using wide signed/unsigned arithmetic.
    function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] ua, input logic [31:0] ub);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(ua));
        sb = longint'($signed(ub));
        p  = 64'd0;
        case (f)
            6'h18: p = 64'(sa * sb);
            6'h19: p = {32'd0, ua} * {32'd0, ub};
            6'h1A: begin
                if (ub == 32'd0) p = {ua, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            6'h1B: begin
                if (ub == 32'd0) p = {ua, 32'hFFFF_FFFF};
                else p = {ua % ub, ua / ub};
            end
            default: p = 64'd0;
        endcase
        return p;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
            end else begin
                chk("done_hilo", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [5:0] f, input logic [31:0] ua, input logic [31:0] ub, input bit push);
        start = 1'b1;
        func  = f;
        a     = ua;
        b     = ub;
        if (push) exp_q.push_back(ref_md(f, ua, ub));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int nbusy);
        bit ok;
        nbusy = 0;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
            if (busy) nbusy++;
        end
        if (!ok) begin
            total++;
            $display("FAIL done_timeout: got no done in 100 cycles expected done");
        end
    endtask

    initial begin
        int nb, d0, bad;
        logic [5:0] f;
        logic [31:0] ra, rb;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_state", {busy, done, hi, lo}, {2'b00, 64'd0});
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        wait_done(nb);
        chk("multu_busy_cycles", 64'(nb), 64'd33);

        issue(6'h18, 32'hFFFF_FFFD, 32'd7, 1);
        wait_done(nb);
        issue(6'h18, 32'h7FFF_FFFF, 32'h8000_0000, 1);
        wait_done(nb);
        chk("b2b_busy_cycles", 64'(nb), 64'd33);

        issue(6'h1A, 32'hFFFF_FFF9, 32'd2, 1);
        wait_done(nb);
        issue(6'h1B, 32'd7, 32'd2, 1);
        wait_done(nb);
        issue(6'h1B, 32'd5, 32'd0, 1);
        wait_done(nb);
        chk("div0_busy_cycles", 64'(nb), 64'd33);
        issue(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        wait_done(nb);
        issue(6'h1A, 32'hFFFF_FFF0, 32'd0, 1);
        wait_done(nb);

        @(negedge clk);
        issue(6'h13, 32'hCAFE_BABE, 32'd0, 0);
        func = 6'h12;
        #1;
        chk("mtlo_mflo", {lo, rd_data}, {32'hCAFE_BABE, 32'hCAFE_BABE});

        // MFHI held against a busy unit
        issue(6'h11, 32'h1234_5678, 32'd0, 0);
        chk("mthi", 64'(hi), 64'h1234_5678);
        issue(6'h18, 32'd3, 32'd4, 1);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        func  = 6'h10;
        bad = 0;
        nb = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                nb = 1;
                break;
            end
            if (!stall) bad++;
        end
        chk("mfhi_stall_held", 64'(bad), 64'd0);
        chk("mfhi_done_seen", 64'(nb), 64'd1);
        chk("mfhi_done_read", {63'd0, stall, rd_data}, 96'd0);
        @(posedge clk);
        #1;
        start = 1'b0;

        // flush in the 10th busy cycle
        issue(6'h11, 32'h1234_5678, 32'd0, 0);
        issue(6'h18, 32'd3, 32'd4, 0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 64'(busy), 64'd0);
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("flush_no_done", 64'(done_cnt), 64'(d0));
        chk("flush_hi_kept", 64'(hi), 64'h1234_5678);

        // reset during CALC
        issue(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midop_reset", {busy, hi, lo}, 65'd0);
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("midop_reset_no_done", 64'(done_cnt), 64'(d0));

        // start with flush in the same cycle
        flush = 1'b1;
        issue(6'h18, 32'd5, 32'd6, 0);
        issue(6'h13, 32'hDEAD_BEEF, 32'd0, 0);
        flush = 1'b0;
        @(negedge clk);
        chk("start_flush_no_accept", {busy, lo}, 33'd0);
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("start_flush_no_done", 64'(done_cnt), 64'(d0));

        // randomized back-to-back operations
        for (int i = 0; i < 24; i++) begin
            f  = 6'h18 + 6'($urandom_range(3));
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            issue(f, ra, rb, 1);
            wait_done(nb);
        end

        @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide sequencer and HI/LO register owner for the MIPS execute stage. It handles the R-type funct codes the combinational ALU does not implement: MULT/MULTU/DIV/DIVU/MFHI/MTHI/MFLO/MTLO. It runs a 32-iteration shift-add multiply or restoring divide on operand magnitudes, then applies the sign fix-up. It raises `stall` to the pipeline while an instruction that needs the unit finds it busy.

## Interface

Parameters: none (fixed 32-bit datapath, 32 iterations).

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: EX-stage instruction targets this unit; qualifies `func`.
- `func` in 6: funct code. 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO, 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU. Others are ignored.
- `A` in 32: rs operand (multiplicand / dividend / MTxx source).
- `B` in 32: rt operand (multiplier / divisor).
- `flush` in 1: pipeline exception/cancel. Aborts any operation in flight.
- `busy` out 1: sequencer not in IDLE.
- `stall` out 1: `busy & start & (func` is a valid unit code); combinational.
- `done` out 1: one-cycle pulse when HI/LO are written by MULT/DIV.
- `hi` out 32: HI register.
- `lo` out 32: LO register.
- `rd_data` out 32: combinational. Equals `hi` when func=0x10, else `lo`. Valid only when `stall`=0.

## Operation

- States: IDLE, CALC, FIX. Internal registers:
  - 6-bit iteration count.
  - 64-bit accumulator (multiply: {product_hi, multiplier}; divide: {remainder, quotient}).
  - 32-bit magnitude operand.
  - `neg_q` and `neg_r` sign flags.
  - `op_div` and `div0` flags.
- Accept occurs when `start & !busy & !flush` and func ∈ {MULT, MULTU, DIV, DIVU}.
  - Signed ops latch |A| and |B|. Set `neg_q = A[31]^B[31]` and `neg_r = A[31]`.
  - Unsigned ops latch A and B raw with both flags clear.
  - State moves to CALC, count=0.
- MTHI/MTLO when `start & !busy & !flush`: write A into HI/LO at that edge. Stay in IDLE, no `done`.
- MFHI/MFLO have no sequential effect. `start` with any other func is ignored.
- CALC performs one iteration per cycle.
  - Multiply: if acc[0], add the operand into acc[63:32] with carry (33-bit add), then shift the whole accumulator right 1.
  - Divide: shift the accumulator left 1, trial-subtract the divisor from acc[63:32]. If the result is non-negative, keep it and set acc[0]=1.
  - At count=31, state moves to FIX.
- FIX, multiply: the 64-bit result is two's-complement negated if `neg_q`. HI gets bits 63:32, LO gets bits 31:0.
- FIX, divide:
  - LO = quotient, negated if `neg_q`.
  - HI = remainder, negated if `neg_r`.
- FIX always returns to IDLE and sets `done`.
- Divide by zero (`div0` = B==0 at accept): still takes full latency. FIX writes LO=0xFFFFFFFF and HI=A (original, unsigned/signed alike).
- Signed 0x80000000 / 0xFFFFFFFF produces LO=0x80000000, HI=0. This falls out of the magnitude arithmetic; no trap.
- `flush` in CALC or FIX: next state is IDLE. HI/LO are not written, no `done`, `busy` clears.
- `flush` has priority over `start` in the same cycle: nothing is accepted or written.

## Timing

- Reset values (`rst_n`=0 at an edge): state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, count=0. This applies equally mid-operation.
- Accept edge E0 puts the unit in CALC. Edges E1..E32 are iterations; E32 moves to FIX. E33 writes HI/LO and returns to IDLE.
- `busy`=1 for exactly 33 cycles, between E0 and E33.
- `done`=1 for the single cycle after E33, with `busy`=0. HI/LO show the new values in the same cycle.
- A new MULT/DIV is accepted at E33+1 at the earliest, in the `done` cycle.
- MTHI/MTLO latency is 1: the value is visible after E0.
- `stall` is combinational. The pipeline holds `start`/`func`/`A`/`B` stable while `stall`=1.
- MFHI issued during `done` reads the new HI.

## Test plan

- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> `busy` high for 33 cycles, then `done` with HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. A second MULT accepted in the `done` cycle yields a correct second result.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1.
- DIVU A=5, B=0 -> LO=0xFFFFFFFF, HI=5 after 33 busy cycles. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x12345678, then MULT 3×4 started:
  - MFHI asserted 5 cycles later -> `stall`=1 until `done`. `rd_data` is then 0x00000000.
  - Repeat with `flush` at the 10th busy cycle -> `busy`=0 next cycle, no `done`, HI stays 0x12345678.
- `rst_n`=0 for one edge during CALC -> next cycle `busy`=0, `hi`=`lo`=0, `done` never pulses. `start` plus `flush` in the same cycle -> no accept.
